decap_v2: RTL

- Receive-side counterpart of the tunnel encapsulator, placed in the user datapath after the input arbiter.
- Detects tunnelled packets: outer Ethernet + IPv4 header (20 B, IHL=5) + 32-bit tag, 38 bytes in total.
- Strips those 38 bytes, realigns the inner frame to word 0, and rewrites the IOQ length header.
- Non-matching packets pass through unmodified.

---
 rtl/decap_v2.sv | 358 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decap_v2.sv
// decap_v2: receive-side tunnel decapsulator.
// A tunnelled packet carries 38 outer bytes: an Ethernet header, a 20-byte
// IPv4 header with IHL=5, and a 32-bit tag. When the outer header matches
// cfg_proto and cfg_tag, those 38 bytes are stripped. The inner frame is
// realigned to word 0 and the IOQ length header is rewritten. All other
// packets pass through unmodified.
//
// Optional feature: define DECAP_PKT_COUNTERS_EN to build the packet
// counters. When the macro is not defined, decap_pkt_cnt and pass_pkt_cnt
// are tied to zero.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   in_data/in_ctrl   input word and ctrl
//   in_wr             input write
//   in_rdy            input ready
//   out_data/out_ctrl output word and ctrl (registered)
//   out_wr            output write (registered)
//   out_rdy           downstream ready
//   cfg_enable        global decap enable
//   cfg_proto         required outer IP protocol
//   cfg_tag           required tunnel tag
//   decap_pkt_cnt     decapsulated packet count (optional feature)
//   pass_pkt_cnt      passed-through packet count (optional feature)

`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif

module decap_v2 #(
  parameter int unsigned DATA_WIDTH           = 64,
  parameter int unsigned CTRL_WIDTH           = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = `IO_QUEUE_STAGE_NUM,
  parameter int unsigned MAX_PKT              = 2048,
  parameter int unsigned DATA_FIFO_DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  cfg_enable,
  input  logic [7:0]            cfg_proto,
  input  logic [31:0]           cfg_tag,
  output logic [31:0]           decap_pkt_cnt,
  output logic [31:0]           pass_pkt_cnt
);

  localparam int unsigned BW            = $clog2(MAX_PKT);   // byte count width
  localparam int unsigned WW            = BW - 3;            // word count width
  localparam int unsigned FIFO_W        = DATA_WIDTH + CTRL_WIDTH;
  localparam int unsigned DEPTH         = 1 << DATA_FIFO_DEPTH_BITS;
  localparam int unsigned CNT_W         = DATA_FIFO_DEPTH_BITS + 1;
  localparam int unsigned DEC_DEPTH     = 4;
  localparam int unsigned DEC_PTR_W     = 2;
  localparam int unsigned DEC_CNT_W     = 3;
  localparam int unsigned TUNNEL_BYTES  = 38;
  localparam int unsigned IOQ_BYTE_LEN_POS = 0;
  localparam int unsigned IOQ_WORD_LEN_POS = 32;
  localparam int unsigned IOQ_LEN_FIELD_W  = 16;

  typedef struct packed {
    logic          decap;
    logic [BW-1:0] blen;
    logic [WW-1:0] wlen;
  } dec_entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_MOD_HDRS, S_PASS, S_DROP, S_LOAD, S_SHIFT, S_LAST
  } state_e;

  // ---------------------------------------------------------------- data FIFO
  logic [FIFO_W-1:0]               dmem [DEPTH];
  logic [DATA_FIFO_DEPTH_BITS-1:0] dwr_ptr_q, drd_ptr_q;
  logic [CNT_W-1:0]                dcnt_q;
  logic                            dfifo_wr_c, dfifo_rd_c, dfifo_empty_c, dfifo_nearly_full_c;
  logic [DATA_WIDTH-1:0]           head_data_c;
  logic [CTRL_WIDTH-1:0]           head_ctrl_c;

  // ------------------------------------------------------------ decision FIFO
  dec_entry_t                      dec_mem [DEC_DEPTH];
  logic [DEC_PTR_W-1:0]            dec_wr_ptr_q, dec_rd_ptr_q;
  logic [DEC_CNT_W-1:0]            dec_cnt_q;
  logic                            dec_push_c, dec_pop_c, dec_empty_c, dec_full_c;
  dec_entry_t                      dec_wdata_c, dec_rdata_c;

  assign dfifo_empty_c       = (dcnt_q == '0);
  assign dfifo_nearly_full_c = (dcnt_q >= CNT_W'(DEPTH - 2));
  assign {head_ctrl_c, head_data_c} = dmem[drd_ptr_q];
  assign dec_empty_c = (dec_cnt_q == '0);
  assign dec_full_c  = (dec_cnt_q == DEC_CNT_W'(DEC_DEPTH));
  assign dec_rdata_c = dec_mem[dec_rd_ptr_q];

  // Upstream is expected to honour in_rdy in the same cycle.
  assign in_rdy     = !dfifo_nearly_full_c && !dec_full_c;
  assign dfifo_wr_c = in_wr && in_rdy;

  // Storage arrays carry no reset; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (dfifo_wr_c) dmem[dwr_ptr_q] <= {in_ctrl, in_data};
    if (dec_push_c) dec_mem[dec_wr_ptr_q] <= dec_wdata_c;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwr_ptr_q    <= '0;
      drd_ptr_q    <= '0;
      dcnt_q       <= '0;
      dec_wr_ptr_q <= '0;
      dec_rd_ptr_q <= '0;
      dec_cnt_q    <= '0;
    end else begin
      if (dfifo_wr_c) dwr_ptr_q <= dwr_ptr_q + 1'b1;
      if (dfifo_rd_c) drd_ptr_q <= drd_ptr_q + 1'b1;
      dcnt_q <= dcnt_q + CNT_W'(dfifo_wr_c) - CNT_W'(dfifo_rd_c);
      if (dec_push_c) dec_wr_ptr_q <= dec_wr_ptr_q + 1'b1;
      if (dec_pop_c)  dec_rd_ptr_q <= dec_rd_ptr_q + 1'b1;
      dec_cnt_q <= dec_cnt_q + DEC_CNT_W'(dec_push_c) - DEC_CNT_W'(dec_pop_c);
    end
  end

  // ------------------------------------------------------------ input parser
  // p_idx_q is the index of the next data word. A value of 5 means this
  // packet's decision has already been pushed.
  logic          p_hdr_q, p_hdr_d;
  logic [2:0]    p_idx_q, p_idx_d;
  logic          p_ok_q, p_ok_d;
  logic [BW-1:0] p_blen_q, p_blen_d;
  logic [WW-1:0] p_wlen_q, p_wlen_d;
  logic          is_eop_c, d1_ok_c, tag_ok_c, decap_c;
  logic [BW-1:0] new_blen_c;
  logic [BW:0]   round_c;
  logic [WW-1:0] new_wlen_c;

  assign new_blen_c = p_blen_q - BW'(TUNNEL_BYTES);
  assign round_c    = {1'b0, new_blen_c} + (BW+1)'(7);
  assign new_wlen_c = round_c[BW-1:3];
  assign d1_ok_c    = (in_data[31:16] == 16'h0800) && (in_data[15:8] == 8'h45);
  assign tag_ok_c   = (in_data[47:16] == cfg_tag);
  assign is_eop_c   = (in_ctrl != '0);
  assign decap_c    = cfg_enable && p_ok_q && tag_ok_c;

  // Parser next state; one decision per packet, at d4 or an earlier EOP.
  always_comb begin
    p_hdr_d     = p_hdr_q;
    p_idx_d     = p_idx_q;
    p_ok_d      = p_ok_q;
    p_blen_d    = p_blen_q;
    p_wlen_d    = p_wlen_q;
    dec_push_c  = 1'b0;
    dec_wdata_c = '{decap: 1'b0, blen: p_blen_q, wlen: p_wlen_q};
    if (dfifo_wr_c) begin
      if (p_hdr_q) begin
        if (in_ctrl == IOQ_STAGE_NUM) begin
          p_blen_d = in_data[IOQ_BYTE_LEN_POS +: BW];
          p_wlen_d = in_data[IOQ_WORD_LEN_POS +: WW];
        end else if (in_ctrl == '0) begin
          p_hdr_d = 1'b0;
          p_idx_d = 3'd1;
          p_ok_d  = 1'b1;
        end
      end else begin
        if (p_idx_q == 3'd1) p_ok_d = p_ok_q && d1_ok_c;
        if (p_idx_q == 3'd2) p_ok_d = p_ok_q && (in_data[7:0] == cfg_proto);
        if (p_idx_q <= 3'd4) begin
          if (is_eop_c) begin
            dec_push_c = 1'b1;
          end else if (p_idx_q == 3'd4) begin
            dec_push_c = 1'b1;
            if (decap_c) dec_wdata_c = '{decap: 1'b1, blen: new_blen_c, wlen: new_wlen_c};
          end
          p_idx_d = p_idx_q + 3'd1;
        end
        if (is_eop_c) p_hdr_d = 1'b1;
      end
    end
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_hdr_q  <= 1'b1;
      p_idx_q  <= '0;
      p_ok_q   <= 1'b0;
      p_blen_q <= '0;
      p_wlen_q <= '0;
    end else begin
      p_hdr_q  <= p_hdr_d;
      p_idx_q  <= p_idx_d;
      p_ok_q   <= p_ok_d;
      p_blen_q <= p_blen_d;
      p_wlen_q <= p_wlen_d;
    end
  end

  // -------------------------------------------------------------- output FSM
  state_e                state_q, state_d;
  dec_entry_t            cur_q, cur_d;
  logic [1:0]            drop_cnt_q, drop_cnt_d;
  logic [15:0]           hold_data_q, hold_data_d;   // only the bytes that shift forward
  logic [1:0]            hold_ctrl_q, hold_ctrl_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic                  out_wr_q, out_wr_d;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    drop_cnt_d  = drop_cnt_q;
    hold_data_d = hold_data_q;
    hold_ctrl_d = hold_ctrl_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    out_wr_d    = 1'b0;
    dfifo_rd_c  = 1'b0;
    dec_pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!dec_empty_c) begin
          dec_pop_c = 1'b1;
          cur_d     = dec_rdata_c;
          state_d   = S_MOD_HDRS;
        end
      end
      S_MOD_HDRS: begin
        if (!dfifo_empty_c) begin
          if (head_ctrl_c != '0) begin
            if (out_rdy) begin
              dfifo_rd_c = 1'b1;
              out_wr_d   = 1'b1;
              out_data_d = head_data_c;
              out_ctrl_d = head_ctrl_c;
              // Passed packets keep their header bit-identical.
              if ((head_ctrl_c == IOQ_STAGE_NUM) && cur_q.decap) begin
                out_data_d[IOQ_BYTE_LEN_POS +: IOQ_LEN_FIELD_W] = IOQ_LEN_FIELD_W'(cur_q.blen);
                out_data_d[IOQ_WORD_LEN_POS +: IOQ_LEN_FIELD_W] = IOQ_LEN_FIELD_W'(cur_q.wlen);
              end
            end
          end else if (cur_q.decap) begin
            drop_cnt_d = '0;
            state_d    = S_DROP;
          end else if (out_rdy) begin
            // Forward d0 while switching, so passthrough adds no bubble.
            dfifo_rd_c = 1'b1;
            out_wr_d   = 1'b1;
            out_data_d = head_data_c;
            out_ctrl_d = head_ctrl_c;
            state_d    = S_PASS;
          end
        end
      end
      S_PASS: begin
        if (!dfifo_empty_c && out_rdy) begin
          dfifo_rd_c = 1'b1;
          out_wr_d   = 1'b1;
          out_data_d = head_data_c;
          out_ctrl_d = head_ctrl_c;
          if (head_ctrl_c != '0) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        // d0..d3 are already stored, because the decision was pushed at d4.
        if (!dfifo_empty_c) begin
          dfifo_rd_c = 1'b1;
          drop_cnt_d = drop_cnt_q + 2'd1;
          if (drop_cnt_q == 2'd3) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!dfifo_empty_c) begin
          dfifo_rd_c  = 1'b1;
          hold_data_d = head_data_c[15:0];
          hold_ctrl_d = head_ctrl_c[1:0];
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!dfifo_empty_c && out_rdy) begin
          dfifo_rd_c  = 1'b1;
          out_wr_d    = 1'b1;
          out_data_d  = {hold_data_q, head_data_c[63:16]};
          out_ctrl_d  = {hold_ctrl_q, head_ctrl_c[7:2]};
          hold_data_d = head_data_c[15:0];
          hold_ctrl_d = head_ctrl_c[1:0];
          // EOP in the low two ctrl bits leaves bytes for one more word.
          if (head_ctrl_c[7:2] != '0)      state_d = S_IDLE;
          else if (head_ctrl_c[1:0] != '0) state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (out_rdy) begin
          out_wr_d   = 1'b1;
          out_data_d = {hold_data_q, 48'h0};
          out_ctrl_d = {hold_ctrl_q, 6'h0};
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      drop_cnt_q  <= '0;
      hold_data_q <= '0;
      hold_ctrl_q <= '0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      out_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      drop_cnt_q  <= drop_cnt_d;
      hold_data_q <= hold_data_d;
      hold_ctrl_q <= hold_ctrl_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_wr   = out_wr_q;

  // --------------------------------------------------------- packet counters
`ifdef DECAP_PKT_COUNTERS_EN
  logic [31:0] decap_cnt_q, pass_cnt_q;

  // Each decision pop is one packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      decap_cnt_q <= '0;
      pass_cnt_q  <= '0;
    end else if (dec_pop_c) begin
      if (dec_rdata_c.decap) decap_cnt_q <= decap_cnt_q + 32'd1;
      else                   pass_cnt_q  <= pass_cnt_q + 32'd1;
    end
  end

  assign decap_pkt_cnt = decap_cnt_q;
  assign pass_pkt_cnt  = pass_cnt_q;
`else
  assign decap_pkt_cnt = '0;
  assign pass_pkt_cnt  = '0;
`endif

endmodule
